// File: rtl/mips150_pkg.sv
// Shared MIPS150 encodings: load mask, store type, and LSU FSM states.
// Also provides helpers that classify an access by size.
package mips150_pkg;

    localparam logic [2:0] MASK_LB  = 3'b000;
    localparam logic [2:0] MASK_LH  = 3'b001;
    localparam logic [2:0] MASK_LW  = 3'b010;
    localparam logic [2:0] MASK_LBU = 3'b011;
    localparam logic [2:0] MASK_LHU = 3'b100;

    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_SB   = 2'b01,
        MW_SH   = 2'b10,
        MW_SW   = 2'b11
    } mem_write_e;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t LSU_IDLE = 2'd0;
    localparam lsu_state_t LSU_REQ  = 2'd1;
    localparam lsu_state_t LSU_DONE = 2'd2;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    // Reserved mask codes fall through to word size, matching LW behaviour.
    function automatic size_e load_size(input logic [2:0] mask);
        case (mask)
            MASK_LB, MASK_LBU: return SZ_BYTE;
            MASK_LH, MASK_LHU: return SZ_HALF;
            default:           return SZ_WORD;
        endcase
    endfunction

    function automatic size_e store_size(input logic [1:0] mem_write);
        case (mem_write)
            MW_SB:   return SZ_BYTE;
            MW_SH:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mips150_lsu_if.sv
// Data-memory req/ack port between the LSU (master) and memory (slave).
interface mips150_lsu_if #(parameter int ADDR_W = 32);
    logic              mem_req;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/mips150_load_extract.sv
// Big-endian lane extraction and sign/zero extension of a loaded word.
module mips150_load_extract
    import mips150_pkg::*;
(
    input  logic [2:0]  mask,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        case (offset)
            2'd0:    lane_byte = rdata[31:24];
            2'd1:    lane_byte = rdata[23:16];
            2'd2:    lane_byte = rdata[15:8];
            default: lane_byte = rdata[7:0];
        endcase
        lane_half = offset[1] ? rdata[15:0] : rdata[31:16];

        case (mask)
            MASK_LB:  data = {{24{lane_byte[7]}}, lane_byte};
            MASK_LH:  data = {{16{lane_half[15]}}, lane_half};
            MASK_LBU: data = {24'h0, lane_byte};
            MASK_LHU: data = {16'h0, lane_half};
            default:  data = rdata;
        endcase
    end
endmodule

// File: rtl/mips150_lsu.sv
// MIPS150 MEM-stage load/store unit: one req/ack memory transaction per access.
// Optional LSU_MISALIGN_TRAP_EN flags misaligned half/word accesses instead of issuing them.
module mips150_lsu
    import mips150_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              mem_to_reg,
    input  logic [2:0]        mask,
    input  logic [1:0]        mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misaligned,
    mips150_lsu_if.master     mem
);
    lsu_state_t  state;
    logic        is_store, access, trap;
    size_e       size;
    logic [3:0]  we_next;
    logic [31:0] wdata_next;
    logic        load_q;
    logic [2:0]  mask_q;
    logic [1:0]  off_q;
    logic [31:0] ext_data;

    always_comb begin
        is_store   = mem_write != MW_NONE;
        access     = valid_in && (is_store || mem_to_reg);
        size       = is_store ? store_size(mem_write) : load_size(mask);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = access && ((size == SZ_HALF && addr[0]) ||
                          (size == SZ_WORD && addr[1:0] != 2'b00));
`else
        trap = 1'b0;
`endif
        we_next    = 4'b0000;
        wdata_next = store_data;
        if (is_store) begin
            case (size)
                SZ_BYTE: begin
                    we_next    = 4'b1000 >> addr[1:0];
                    wdata_next = {4{store_data[7:0]}};
                end
                SZ_HALF: begin
                    we_next    = addr[1] ? 4'b0011 : 4'b1100;
                    wdata_next = {2{store_data[15:0]}};
                end
                default: we_next = 4'b1111;
            endcase
        end
    end

    // Reset gates stall so an abandoned request releases the pipeline at once.
    assign stall       = ~rst & ((state == LSU_IDLE && access && !trap) || state == LSU_REQ);
    assign mem.mem_req = state == LSU_REQ;
    assign load_valid  = state == LSU_DONE && load_q;

    mips150_load_extract u_extract (
        .mask   (mask_q),
        .offset (off_q),
        .rdata  (mem.mem_rdata),
        .data   (ext_data)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LSU_IDLE;
            load_q        <= 1'b0;
            mask_q        <= '0;
            off_q         <= '0;
            mem.mem_we    <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            load_data     <= '0;
            misaligned    <= 1'b0;
        end else begin
            misaligned <= state == LSU_IDLE && trap;
            case (state)
                LSU_IDLE: begin
                    if (access && !trap) begin
                        state         <= LSU_REQ;
                        load_q        <= !is_store;
                        mask_q        <= mask;
                        off_q         <= addr[1:0];
                        mem.mem_we    <= we_next;
                        mem.mem_wdata <= wdata_next;
                        mem.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                    end
                end
                LSU_REQ: begin
                    if (mem.mem_ack) begin
                        if (load_q)
                            load_data <= ext_data;
                        state <= LSU_DONE;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end
endmodule
